// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I core: controller state
// encoding, opcode constants and datapath select encodings.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_FAULT    = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/instr_immdec.sv
// Opcode to immediate-format decoder; purely combinational.
module instr_immdec
    import riscv_pkg::*;
(
    input  logic [6:0] op_i,
    output logic [1:0] imm_src_o
);

    // Map opcode to immediate format; unknown opcodes default to I.
    always_comb begin
        imm_src_o = IMM_I;
        case (op_i)
            OP_LW, OP_I: imm_src_o = IMM_I;
            OP_SW:       imm_src_o = IMM_S;
            OP_BEQ:      imm_src_o = IMM_B;
            OP_JAL:      imm_src_o = IMM_J;
            default:     imm_src_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core.
// Optional macro MC_BNE_EN: branch state also executes bne (funct3=001)
// and branches with any other funct3 trap in DECODE.
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       fault
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             fault_q, fault_d;
    logic             timeout;
    logic             wait_state;
    logic             branch_taken;
    logic             branch_legal;

`ifdef MC_BNE_EN
    assign branch_taken = (funct3 == F3_BNE) ? ~Zero : Zero;
    assign branch_legal = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
`else
    logic unused_funct3;
    assign unused_funct3 = ^funct3;
    assign branch_taken  = Zero;
    assign branch_legal  = 1'b1;
`endif

    // Timeout fires on the cycle the wait count would reach WAIT_LIMIT.
    generate
        if (WAIT_LIMIT > 0) begin : g_timeout
            assign timeout = (wait_cnt_q == CNT_W'(WAIT_LIMIT - 1));
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

    assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                        (state_q == S_MEMWRITE);

    instr_immdec u_immdec (
        .op_i      (op),
        .imm_src_o (ImmSrc)
    );

    // State, wait counter and sticky fault registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
        end
    end

    // Next-state and Moore outputs; strobes qualified by mem_ready/Zero.
    always_comb begin
        state_d   = state_q;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALUOP_ADD;
        RegWrite  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready)    state_d = S_DECODE;
                else if (timeout) state_d = S_FAULT;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = branch_legal ? S_BEQ : S_FAULT;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready)    state_d = S_MEMWB;
                else if (timeout) state_d = S_FAULT;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready)    state_d = S_FETCH;
                else if (timeout) state_d = S_FAULT;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALUOP_SUB;
                PCWrite = branch_taken;
                state_d = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
        // A reset cycle must never commit architectural state.
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

    // Wait counter restarts on every state change and counts stalled cycles.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q)
            wait_cnt_d = '0;
        else if (wait_state && !mem_ready && (WAIT_LIMIT != 0))
            wait_cnt_d = wait_cnt_q + 1'b1;
    end

    assign fault_d = fault_q | (state_d == S_FAULT);
    assign fault   = fault_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with WAIT_LIMIT=4.
module tb_multicycle_ctrl;

    localparam logic [6:0] C_LW  = 7'b0000011;
    localparam logic [6:0] C_SW  = 7'b0100011;
    localparam logic [6:0] C_R   = 7'b0110011;
    localparam logic [6:0] C_I   = 7'b0010011;
    localparam logic [6:0] C_BR  = 7'b1100011;
    localparam logic [6:0] C_JAL = 7'b1101111;
    localparam logic [6:0] C_BAD = 7'b1111111;

    typedef enum int {
        P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
        P_EXECR, P_EXECI, P_ALUWB, P_BEQ, P_JAL, P_FAULT
    } phase_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, fault;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [15:0] obs;

    logic [15:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.WAIT_LIMIT(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .Zero(Zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .fault(fault)
    );

    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                  ALUSrcB, ALUOp, ImmSrc, RegWrite, fault};

    // Expected output word for a controller step, written from the state table.
    function automatic logic [15:0] exp_word(phase_t p, logic rst, logic [6:0] o,
                                             logic [2:0] f3, logic z, logic mr);
        logic pcw, adr, memw, irw, regw, flt;
        logic [1:0] res, sa, sb, aop, imm;
        pcw = 0; adr = 0; memw = 0; irw = 0; regw = 0; flt = 0;
        res = 2'b00; sa = 2'b00; sb = 2'b00; aop = 2'b00; imm = 2'b00;
        if (o == C_SW) imm = 2'b01;
        else if (o == C_BR) imm = 2'b10;
        else if (o == C_JAL) imm = 2'b11;
        case (p)
            P_FETCH:    begin sb = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
            P_DECODE:   begin sa = 2'b01; sb = 2'b01; end
            P_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            P_MEMREAD:  adr = 1;
            P_MEMWB:    begin res = 2'b01; regw = 1; end
            P_MEMWRITE: begin adr = 1; memw = 1; end
            P_EXECR:    begin sa = 2'b10; aop = 2'b10; end
            P_EXECI:    begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            P_ALUWB:    regw = 1;
            P_BEQ: begin
                sa = 2'b10; aop = 2'b01;
`ifdef MC_BNE_EN
                pcw = (f3 == 3'b001) ? ~z : z;
`else
                pcw = z;
                if (f3 == 3'b111) pcw = z;
`endif
            end
            P_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            P_FAULT:    flt = 1;
            default:    flt = 0;
        endcase
        if (rst) begin pcw = 0; irw = 0; memw = 0; regw = 0; end
        return {pcw, adr, memw, irw, res, sa, sb, aop, imm, regw, flt};
    endfunction

    // One clock cycle: drive inputs, queue expectation, check at negedge.
    task automatic cyc(input phase_t p, input logic rst, input logic [6:0] o,
                       input logic [2:0] f3, input logic z, input logic mr,
                       input string tag);
        logic [15:0] e;
        reset = rst; op = o; funct3 = f3; Zero = z; mem_ready = mr;
        exp_q.push_back(exp_word(p, rst, o, f3, z, mr));
        @(negedge clk);
        e = exp_q.pop_front();
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
        $display("[TB] %s obs=%h", tag, obs);
        @(posedge clk); #1;
    endtask

    initial begin
        @(posedge clk); #1;
        cyc(P_FETCH,    1, C_R,  3'd0, 0, 1, "reset_hold");
        // add, zero-wait: 4 cycles
        cyc(P_FETCH,    0, C_R,  3'd0, 0, 1, "add_fetch");
        cyc(P_DECODE,   0, C_R,  3'd0, 0, 1, "add_decode");
        cyc(P_EXECR,    0, C_R,  3'd0, 0, 1, "add_execr");
        cyc(P_ALUWB,    0, C_R,  3'd0, 0, 1, "add_aluwb");
        // lw with 3 wait cycles: 8 cycles
        cyc(P_FETCH,    0, C_LW, 3'd2, 0, 1, "lw_fetch");
        cyc(P_DECODE,   0, C_LW, 3'd2, 0, 1, "lw_decode");
        cyc(P_MEMADR,   0, C_LW, 3'd2, 0, 1, "lw_memadr");
        for (int i = 0; i < 3; i++)
            cyc(P_MEMREAD, 0, C_LW, 3'd2, 0, 0, "lw_memread_wait");
        cyc(P_MEMREAD,  0, C_LW, 3'd2, 0, 1, "lw_memread_rdy");
        cyc(P_MEMWB,    0, C_LW, 3'd2, 0, 1, "lw_memwb");
        // addi
        cyc(P_FETCH,    0, C_I,  3'd0, 0, 1, "addi_fetch");
        cyc(P_DECODE,   0, C_I,  3'd0, 0, 1, "addi_decode");
        cyc(P_EXECI,    0, C_I,  3'd0, 0, 1, "addi_execi");
        cyc(P_ALUWB,    0, C_I,  3'd0, 0, 1, "addi_aluwb");
        // beq taken, then not taken
        cyc(P_FETCH,    0, C_BR, 3'd0, 1, 1, "beq1_fetch");
        cyc(P_DECODE,   0, C_BR, 3'd0, 1, 1, "beq1_decode");
        cyc(P_BEQ,      0, C_BR, 3'd0, 1, 1, "beq1_taken");
        cyc(P_FETCH,    0, C_BR, 3'd0, 0, 1, "beq0_fetch");
        cyc(P_DECODE,   0, C_BR, 3'd0, 0, 1, "beq0_decode");
        cyc(P_BEQ,      0, C_BR, 3'd0, 0, 1, "beq0_not_taken");
        // branch with funct3=001 and Zero=0
        cyc(P_FETCH,    0, C_BR, 3'd1, 0, 1, "bne_fetch");
        cyc(P_DECODE,   0, C_BR, 3'd1, 0, 1, "bne_decode");
        cyc(P_BEQ,      0, C_BR, 3'd1, 0, 1, "bne_z0");
        cyc(P_FETCH,    0, C_BR, 3'd1, 1, 1, "bne1_fetch");
        cyc(P_DECODE,   0, C_BR, 3'd1, 1, 1, "bne1_decode");
        cyc(P_BEQ,      0, C_BR, 3'd1, 1, 1, "bne_z1");
        // jal, with two wait cycles in FETCH first
        cyc(P_FETCH,    0, C_JAL, 3'd0, 0, 0, "jal_fetch_wait");
        cyc(P_FETCH,    0, C_JAL, 3'd0, 0, 0, "jal_fetch_wait");
        cyc(P_FETCH,    0, C_JAL, 3'd0, 0, 1, "jal_fetch");
        cyc(P_DECODE,   0, C_JAL, 3'd0, 0, 1, "jal_decode");
        cyc(P_JAL,      0, C_JAL, 3'd0, 0, 1, "jal_jal");
        cyc(P_ALUWB,    0, C_JAL, 3'd0, 0, 1, "jal_aluwb");
        // sw, handshake arrives exactly on the limit cycle
        cyc(P_FETCH,    0, C_SW, 3'd2, 0, 1, "swlim_fetch");
        cyc(P_DECODE,   0, C_SW, 3'd2, 0, 1, "swlim_decode");
        cyc(P_MEMADR,   0, C_SW, 3'd2, 0, 1, "swlim_memadr");
        for (int i = 0; i < 3; i++)
            cyc(P_MEMWRITE, 0, C_SW, 3'd2, 0, 0, "swlim_wait");
        cyc(P_MEMWRITE, 0, C_SW, 3'd2, 0, 1, "swlim_rdy");
        // reset during MEMWRITE
        cyc(P_FETCH,    0, C_SW, 3'd2, 0, 1, "swrst_fetch");
        cyc(P_DECODE,   0, C_SW, 3'd2, 0, 1, "swrst_decode");
        cyc(P_MEMADR,   0, C_SW, 3'd2, 0, 1, "swrst_memadr");
        cyc(P_MEMWRITE, 1, C_SW, 3'd2, 0, 0, "swrst_reset");
        cyc(P_FETCH,    0, C_SW, 3'd2, 0, 1, "swrst_after");
        cyc(P_DECODE,   0, C_SW, 3'd2, 0, 1, "swrst_decode2");
        cyc(P_MEMADR,   0, C_SW, 3'd2, 0, 1, "swrst_memadr2");
        cyc(P_MEMWRITE, 0, C_SW, 3'd2, 0, 1, "swrst_write");
        // sw timeout: 4 MemWrite cycles, then FAULT
        cyc(P_FETCH,    0, C_SW, 3'd2, 0, 1, "swto_fetch");
        cyc(P_DECODE,   0, C_SW, 3'd2, 0, 1, "swto_decode");
        cyc(P_MEMADR,   0, C_SW, 3'd2, 0, 1, "swto_memadr");
        for (int i = 0; i < 4; i++)
            cyc(P_MEMWRITE, 0, C_SW, 3'd2, 0, 0, "swto_wait");
        cyc(P_FAULT,    0, C_SW, 3'd2, 0, 1, "swto_fault");
        cyc(P_FAULT,    1, C_SW, 3'd2, 0, 1, "swto_reset");
        // FETCH timeout
        for (int i = 0; i < 4; i++)
            cyc(P_FETCH, 0, C_R, 3'd0, 0, 0, "fetchto_wait");
        cyc(P_FAULT,    0, C_R,  3'd0, 0, 1, "fetchto_fault");
        cyc(P_FAULT,    1, C_R,  3'd0, 0, 1, "fetchto_reset");
        // illegal opcode: absorbing FAULT until reset
        cyc(P_FETCH,    0, C_BAD, 3'd0, 1, 1, "bad_fetch");
        cyc(P_DECODE,   0, C_BAD, 3'd0, 1, 1, "bad_decode");
        for (int i = 0; i < 11; i++)
            cyc(P_FAULT, 0, C_BAD, 3'd0, 1, 1, "bad_fault_hold");
        cyc(P_FAULT,    1, C_BAD, 3'd0, 1, 1, "bad_reset");
        cyc(P_FETCH,    0, C_R,  3'd0, 0, 1, "bad_after_reset");
`ifdef MC_BNE_EN
        // unsupported branch funct3 traps in DECODE
        cyc(P_DECODE,   0, C_BR, 3'd4, 0, 1, "blt_decode");
        cyc(P_FAULT,    0, C_BR, 3'd4, 0, 1, "blt_fault");
        cyc(P_FAULT,    1, C_BR, 3'd4, 0, 1, "blt_reset");
        cyc(P_FETCH,    0, C_R,  3'd0, 0, 1, "blt_after_reset");
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
